// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladder cell, LSB-first, WIDTH+1 cycles per add.
// Sum, carry-out and signed overflow are registered and held until the next done.
module fulladder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic S,
   output logic cout
);
   assign S    = A ^ B ^ cin;
   assign cout = (A & B) | (cin & (A ^ B));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] sa, sb;
   logic [WIDTH-1:1] ss;
   logic [WIDTH-1:0] nxt;
   logic [CW-1:0]    cnt;
   logic             c, c_msb_in;
   logic             fa_s, fa_co;

   fulladder u_fa (
      .A    (sa[0]),
      .B    (sb[0]),
      .cin  (c),
      .S    (fa_s),
      .cout (fa_co)
   );

   // ss only needs WIDTH-1 bits: the final bit comes straight from the cell
   assign nxt = {fa_s, ss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa       <= '0;
         sb       <= '0;
         ss       <= '0;
         cnt      <= '0;
         c        <= 1'b0;
         c_msb_in <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (state == IDLE && start) begin
         sa  <= a;
         sb  <= b;
         c   <= cin;
         cnt <= '0;
      end else if (state == SHIFT) begin
         c  <= fa_co;
         ss <= nxt[WIDTH-1:1];
         sa <= sa >> 1;
         sb <= sb >> 1;
         if (cnt != LAST) cnt <= cnt + CW'(1);
         if (cnt == PENULT) c_msb_in <= fa_co;
         if (cnt == LAST) begin
            sum      <= nxt;
            cout     <= fa_co;
            overflow <= c_msb_in ^ fa_co;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors
// and an exhaustive WIDTH=2 sweep with start held high.
module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         fails = 0;

   logic       start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   logic       start2 = 1'b0, cin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy2, done2, cout2, ovf2;
   logic [1:0] sum2;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ov;
      int         t;
   } exp_t;

   exp_t q8[$];
   exp_t q2[$];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8),
      .cout(cout8), .overflow(ovf8)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2),
      .cout(cout2), .overflow(ovf2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitors: pop one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) begin
            chk("unexpected_done8", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = q8.pop_front();
            chk("res8", {22'b0, sum8, cout8, ovf8}, {22'b0, e.s, e.co, e.ov});
            chk("lat8", 32'(cyc), 32'(e.t));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done2) begin
         if (q2.size() == 0) begin
            chk("unexpected_done2", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = q2.pop_front();
            chk("res2", {28'b0, sum2, cout2, ovf2}, {28'b0, e.s[1:0], e.co, e.ov});
            chk("lat2", 32'(cyc), 32'(e.t));
         end
      end
   end

   task automatic wait_idle8();
      for (int i = 0; i < 20 && busy8; i++) begin
         @(posedge clk);
         #1;
      end
      chk("idle8_timeout", {31'b0, busy8}, 32'd0);
   endtask

   // called #1 after a rising edge with dut8 idle
   task automatic add8(input logic [7:0] ta, input logic [7:0] tb2,
                       input logic tc, input logic [7:0] es,
                       input logic ec, input logic eo);
      a8 = ta;
      b8 = tb2;
      cin8 = tc;
      start8 = 1'b1;
      q8.push_back('{es, ec, eo, cyc + 1 + 8});
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8 = ~ta;
      b8 = ~tb2;
      cin8 = ~tc;
      wait_idle8();
   endtask

   initial begin
      logic [4:0] v;
      logic [2:0] full;
      logic [1:0] es;
      int         tnext;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs8", {27'b0, busy8, done8, cout8, ovf8, |sum8}, 32'd0);
      chk("rst_outs2", {27'b0, busy2, done2, cout2, ovf2, |sum2}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
      add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      add8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

      // start pulses while busy must be ignored
      a8 = 8'h10;
      b8 = 8'h20;
      cin8 = 1'b0;
      start8 = 1'b1;
      q8.push_back('{8'h30, 1'b0, 1'b0, cyc + 1 + 8});
      @(posedge clk);
      #1;
      for (int k = 1; k <= 10; k++) begin
         start8 = (k == 3 || k == 9);
         a8 = 8'hFF;
         b8 = 8'hFF;
         @(posedge clk);
         #1;
         chk($sformatf("busy_k%0d", k), {31'b0, busy8}, (k <= 8) ? 32'd1 : 32'd0);
      end
      start8 = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // asynchronous reset in the middle of an addition
      a8 = 8'h0F;
      b8 = 8'h01;
      cin8 = 1'b0;
      start8 = 1'b1;
      q8.push_back('{8'h10, 1'b0, 1'b0, cyc + 1 + 8});
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("busy_before_rst", {31'b0, busy8}, 32'd1);
      rst_n = 1'b0;
      q8.delete();
      #1;
      chk("async_rst", {23'b0, busy8, done8, sum8, cout8, ovf8}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("idle_after_rst", {31'b0, busy8}, 32'd0);
      add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

      // exhaustive WIDTH=2, start held high: one result every 4 cycles
      tnext = cyc + 1;
      for (int i = 0; i < 32; i++) begin
         v = 5'(i);
         a2 = v[1:0];
         b2 = v[3:2];
         cin2 = v[4];
         start2 = 1'b1;
         full = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
         es = full[1:0];
         q2.push_back('{{6'b0, es}, full[2],
                        (a2[1] == b2[1]) && (es[1] != a2[1]), tnext + 2});
         tnext += 4;
         @(posedge clk);
         repeat (3) @(posedge clk);
         #1;
      end
      start2 = 1'b0;

      for (int i = 0; i < 50 && (q8.size() != 0 || q2.size() != 0); i++)
         @(posedge clk);
      repeat (2) @(posedge clk);
      chk("drain", 32'(q8.size() + q2.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
